// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hazard_state_t;

  // Enables and bubble selects for the PC and the four pipeline latches.
  typedef struct packed {
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
    logic load_memwb;
    logic flush_ifid;
    logic flush_idex;
  } latch_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use comparator: EX load whose destination is read by the ID instruction.
module load_use_detect #(
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 idex_mem_read,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_use_rs1,
  input  logic                 ifid_use_rs2,
  output logic                 hazard_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = ifid_use_rs1 && (ifid_rs1 == idex_rd);
  assign rs2_hit  = ifid_use_rs2 && (ifid_rs2 == idex_rd);
  // x0 is hardwired zero, so a load into it never creates a dependency.
  assign hazard_c = idex_mem_read && (idex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_IDX_W   = 5,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic                   imem_resp,
  input  logic                   mem_req,
  input  logic                   dmem_resp,
  input  logic                   idex_mem_read,
  input  logic [REG_IDX_W-1:0]   idex_rd,
  input  logic [REG_IDX_W-1:0]   ifid_rs1,
  input  logic [REG_IDX_W-1:0]   ifid_rs2,
  input  logic                   ifid_use_rs1,
  input  logic                   ifid_use_rs2,
  input  logic                   br_taken,
  output logic                   load_pc,
  output logic                   load_ifid,
  output logic                   load_idex,
  output logic                   load_exmem,
  output logic                   load_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   pc_redirect,
`ifdef HAZARD_PERF_CNT_EN
  output logic [STALL_CNT_W-1:0] freeze_cycles,
  output logic [STALL_CNT_W-1:0] loaduse_bubbles,
  output logic [STALL_CNT_W-1:0] redirect_flushes,
`endif
  output logic                   frozen
);

  hazard_state_t state;
  logic          i_done;
  logic          d_done;
  logic          redir_pend;

  logic          in_freeze;
  logic          i_ok;
  logic          d_ok;
  logic          advance;
  logic          lu_hazard;
  logic          redirect;
  logic          lu_bubble;
  logic          redir_apply;
  latch_ctrl_t   ctrl;

  load_use_detect #(
    .REG_IDX_W (REG_IDX_W)
  ) u_load_use (
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_use_rs1  (ifid_use_rs1),
    .ifid_use_rs2  (ifid_use_rs2),
    .hazard_c      (lu_hazard)
  );

  // Remembered responses and redirects only exist while frozen.
  assign in_freeze = (state == FREEZE);
  assign i_ok      = !if_req  || imem_resp || (i_done && in_freeze);
  assign d_ok      = !mem_req || dmem_resp || (d_done && in_freeze);
  assign advance   = i_ok && d_ok;
  assign redirect  = br_taken || (redir_pend && in_freeze);

  // Latch control decode: reset, freeze, redirect, load-use, normal flow.
  always_comb begin
    ctrl        = '0;
    pc_redirect = 1'b0;
    frozen      = 1'b0;
    lu_bubble   = 1'b0;
    redir_apply = 1'b0;
    if (!rst) begin
      ctrl.flush_ifid = 1'b1;
      ctrl.flush_idex = 1'b1;
    end else if (!advance) begin
      frozen = 1'b1;
    end else begin
      ctrl.load_pc    = 1'b1;
      ctrl.load_ifid  = 1'b1;
      ctrl.load_idex  = 1'b1;
      ctrl.load_exmem = 1'b1;
      ctrl.load_memwb = 1'b1;
      if (redirect) begin
        // The ID instruction is on the wrong path, so its hazard is moot.
        pc_redirect     = 1'b1;
        ctrl.flush_ifid = 1'b1;
        ctrl.flush_idex = 1'b1;
        redir_apply     = 1'b1;
      end else if (lu_hazard) begin
        ctrl.load_pc    = 1'b0;
        ctrl.load_ifid  = 1'b0;
        ctrl.flush_idex = 1'b1;
        lu_bubble       = 1'b1;
      end
    end
  end

  assign load_pc    = ctrl.load_pc;
  assign load_ifid  = ctrl.load_ifid;
  assign load_idex  = ctrl.load_idex;
  assign load_exmem = ctrl.load_exmem;
  assign load_memwb = ctrl.load_memwb;
  assign flush_ifid = ctrl.flush_ifid;
  assign flush_idex = ctrl.flush_idex;

  // Freeze state and the responses/redirect collected while frozen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      redir_pend <= 1'b0;
    end else if (advance) begin
      state      <= RUN;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      state      <= FREEZE;
      i_done     <= (i_done && in_freeze) || imem_resp;
      d_done     <= (d_done && in_freeze) || dmem_resp;
      redir_pend <= (redir_pend && in_freeze) || br_taken;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      freeze_cycles    <= '0;
      loaduse_bubbles  <= '0;
      redirect_flushes <= '0;
    end else begin
      if (frozen && (freeze_cycles != CNT_MAX))
        freeze_cycles <= freeze_cycles + STALL_CNT_W'(1);
      if (lu_bubble && (loaduse_bubbles != CNT_MAX))
        loaduse_bubbles <= loaduse_bubbles + STALL_CNT_W'(1);
      if (redir_apply && (redirect_flushes != CNT_MAX))
        redirect_flushes <= redirect_flushes + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle model compare plus literal pins.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned STALL_CNT_W = 32;

  // Output vector: {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
  //                 flush_ifid, flush_idex, pc_redirect, frozen}
  localparam logic [8:0] V_RESET  = 9'b00000_11_0_0;
  localparam logic [8:0] V_RUN    = 9'b11111_00_0_0;
  localparam logic [8:0] V_FROZEN = 9'b00000_00_0_1;
  localparam logic [8:0] V_BUBBLE = 9'b00111_01_0_0;
  localparam logic [8:0] V_REDIR  = 9'b11111_11_1_0;

  logic clk = 1'b0;
  logic rst;
  logic if_req, imem_resp, mem_req, dmem_resp;
  logic idex_mem_read;
  logic [REG_IDX_W-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic ifid_use_rs1, ifid_use_rs2, br_taken;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic flush_ifid, flush_idex, pc_redirect, frozen;
`ifdef HAZARD_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] freeze_cycles, loaduse_bubbles, redirect_flushes;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Model state: what the pipeline has already received while stuck.
  bit got_i, got_d, owe_redirect, was_stuck;

  pipeline_hazard_ctrl #(
    .REG_IDX_W   (REG_IDX_W),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .imem_resp        (imem_resp),
    .mem_req          (mem_req),
    .dmem_resp        (dmem_resp),
    .idex_mem_read    (idex_mem_read),
    .idex_rd          (idex_rd),
    .ifid_rs1         (ifid_rs1),
    .ifid_rs2         (ifid_rs2),
    .ifid_use_rs1     (ifid_use_rs1),
    .ifid_use_rs2     (ifid_use_rs2),
    .br_taken         (br_taken),
    .load_pc          (load_pc),
    .load_ifid        (load_ifid),
    .load_idex        (load_idex),
    .load_exmem       (load_exmem),
    .load_memwb       (load_memwb),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .pc_redirect      (pc_redirect),
`ifdef HAZARD_PERF_CNT_EN
    .freeze_cycles    (freeze_cycles),
    .loaduse_bubbles  (loaduse_bubbles),
    .redirect_flushes (redirect_flushes),
`endif
    .frozen           (frozen)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
            flush_ifid, flush_idex, pc_redirect, frozen};
  endfunction

  // Expected outputs from the pipeline rules, given current inputs and history.
  function automatic logic [8:0] model_vec();
    bit waiting_i, waiting_d, squash, dep;
    if (!rst) return V_RESET;
    waiting_i = if_req  && !imem_resp && !got_i;
    waiting_d = mem_req && !dmem_resp && !got_d;
    if (waiting_i || waiting_d) return V_FROZEN;
    squash = br_taken || owe_redirect;
    if (squash) return V_REDIR;
    dep = idex_mem_read && (idex_rd != 0) &&
          ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    if (dep) return V_BUBBLE;
    return V_RUN;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Model history update at each clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      got_i = 0; got_d = 0; owe_redirect = 0;
    end else begin
      was_stuck = (model_vec() == V_FROZEN);
      if (was_stuck) begin
        got_i        = got_i || imem_resp;
        got_d        = got_d || dmem_resp;
        owe_redirect = owe_redirect || br_taken;
      end else begin
        got_i = 0; got_d = 0; owe_redirect = 0;
      end
    end
  end

  // Continuous per-cycle compare against the model.
  always @(negedge clk) check("model", dut_vec(), model_vec());

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [8:0] exp);
    @(negedge clk);
    #1;
    check(name, dut_vec(), exp);
  endtask

  task automatic idle_inputs();
    if_req = 0; imem_resp = 0; mem_req = 0; dmem_resp = 0;
    idex_mem_read = 0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    ifid_use_rs1 = 0; ifid_use_rs2 = 0; br_taken = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    got_i = 0; got_d = 0; owe_redirect = 0; was_stuck = 0;

    // Reset held two cycles
    lit("reset0", V_RESET);
    tick();
    lit("reset1", V_RESET);
    tick();
    rst = 1;
    lit("release", V_RUN);

    // I-miss for three cycles
    tick(); if_req = 1;
    for (int k = 0; k < 3; k++) begin
      lit("imiss_frozen", V_FROZEN);
      tick();
    end
    imem_resp = 1;
    lit("imiss_adv", V_RUN);
    tick(); imem_resp = 0;
    lit("idone_cleared", V_FROZEN);
    tick(); imem_resp = 1;
    lit("imiss2_adv", V_RUN);
    tick(); idle_inputs();

    // Split miss: I responds cycle 1, D responds cycle 4
    if_req = 1; mem_req = 1;
    lit("split_c0", V_FROZEN);
    tick(); imem_resp = 1;
    lit("split_c1", V_FROZEN);
    tick(); imem_resp = 0;
    lit("split_c2", V_FROZEN);
    tick();
    lit("split_c3", V_FROZEN);
    tick(); dmem_resp = 1;
    lit("split_c4_adv", V_RUN);
    tick(); idle_inputs();

    // Load-use on rs2
    idex_mem_read = 1; idex_rd = 5'd5; ifid_rs1 = 5'd3; ifid_use_rs1 = 1;
    ifid_rs2 = 5'd5; ifid_use_rs2 = 1;
    lit("lu_bubble", V_BUBBLE);
    tick(); idex_mem_read = 0;
    lit("lu_after", V_RUN);
    // Load into x0
    tick(); idex_mem_read = 1; idex_rd = 5'd0; ifid_rs2 = 5'd0;
    lit("lu_x0", V_RUN);
    // Match on rs1 but rs1 unused
    tick(); idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_use_rs1 = 0; ifid_rs2 = 5'd1;
    lit("lu_unused_rs1", V_RUN);
    tick(); ifid_use_rs1 = 1;
    lit("lu_rs1", V_BUBBLE);

    // Redirect wins over load-use
    tick(); idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_use_rs2 = 1; br_taken = 1;
    lit("redir_over_lu", V_REDIR);
    tick(); idle_inputs();

    // Redirect during D-miss, applied on response
    mem_req = 1; br_taken = 1;
    lit("redir_frz0", V_FROZEN);
    tick(); br_taken = 0;
    lit("redir_frz1", V_FROZEN);
    tick(); dmem_resp = 1;
    lit("redir_apply", V_REDIR);
    tick(); idle_inputs();
    lit("redir_cleared", V_RUN);

    // Response arriving the same cycle the miss starts
    tick(); mem_req = 1; dmem_resp = 1;
    lit("same_cycle_resp", V_RUN);
    tick(); idle_inputs();

    // Reset in the middle of a freeze
    if_req = 1;
    lit("frz_before_rst", V_FROZEN);
    tick(); rst = 0;
    lit("rst_in_frz", V_RESET);
    tick(); rst = 1; idle_inputs();
    lit("after_rst", V_RUN);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load and bubble-flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. It freezes the whole pipeline on instruction or data cache misses and tracks which cache has already responded. It inserts load-use bubbles and squashes wrong-path instructions on EX-resolved redirects, holding a redirect pending across a freeze.

Parameters:
REG_IDX_W, 5, register index width
STALL_CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
if_req  in  1  fetch outstanding this cycle
imem_resp  in  1  I-cache response valid
mem_req  in  1  MEM-stage instruction reads or writes memory
dmem_resp  in  1  D-cache response valid
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  REG_IDX_W  destination register of the instruction in EX
ifid_rs1, ifid_rs2  in  REG_IDX_W  source registers of the instruction in ID
ifid_use_rs1, ifid_use_rs2  in  1  ID instruction actually reads rs1/rs2
br_taken  in  1  EX resolved a taken branch, JAL or JALR
load_pc, load_ifid, load_idex, load_exmem, load_memwb  out  1  latch enables
flush_ifid, flush_idex  out  1  load NOP/bubble control word instead of incoming data
pc_redirect  out  1  PC mux selects the EX redirect target (captured target when pending)
frozen  out  1  pipeline frozen on a memory miss

Behaviour:
- States: RUN, FREEZE (1 state bit). Registers: i_done, d_done, redir_pend.
- rst low at a clock edge: state=RUN, i_done=d_done=redir_pend=0. Outputs are combinational from registered state and inputs. While in reset: all load_*=0, flush_*=1, pc_redirect=0, frozen=0.
- i_ok = ~if_req | imem_resp | i_done; d_ok = ~mem_req | dmem_resp | d_done; advance = i_ok & d_ok.
- Not advance: all load_*=0, flush_*=0, frozen=1, next state FREEZE.
  - imem_resp sets i_done; dmem_resp sets d_done.
  - br_taken sets redir_pend; the EX latch holds the target stable.
- Advance (RUN or FREEZE→RUN): clear i_done and d_done; frozen=0; all load_* default to 1.
- Priority on advance: redirect > load-use.
  - Redirect (br_taken | redir_pend): pc_redirect=1, flush_ifid=1, flush_idex=1, clear redir_pend. Any load-use hazard is ignored because the ID instruction is squashed.
  - Load-use: idex_mem_read & idex_rd≠0 & ((ifid_use_rs1 & rs1==idex_rd) | (ifid_use_rs2 & rs2==idex_rd)). Then load_pc=0, load_ifid=0, flush_idex=1; EX/MEM and MEM/WB still load. Exactly one bubble; the next cycle sees no match because the load has moved to MEM.
- Responses arriving in the same cycle the freeze begins count immediately; a pipeline never waits for a response already received.
- No combinational path from load_* back into any input.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs freeze_cycles, loaduse_bubbles and redirect_flushes, each STALL_CNT_W bits, cleared by rst, saturating at all-ones.
  - freeze_cycles increments every cycle frozen=1.
  - loaduse_bubbles increments on each inserted load-use bubble.
  - redirect_flushes increments on each applied redirect.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- types package: hazard_state_t enum {RUN, FREEZE}; latch_ctrl_t struct grouping the five load bits and two flush bits.
- One sub-module, load_use_detect: purely combinational comparator with the REG_IDX_W compare and x0 exclusion.

Test Plan:
- Reset: rst=0 for 2 cycles → load_*=0, flush_*=1. Release → all load_*=1, frozen=0 with no requests.
- I-miss: if_req=1, imem_resp low 3 cycles then high → frozen=1 for exactly 3 cycles, all loads 0. Cycle 4: loads 1, i_done cleared.
- Split miss: if_req and mem_req both set; imem_resp pulses cycle 1, dmem_resp pulses cycle 4 → frozen for cycles 0–3. Advance on cycle 4 with no re-wait for the I-cache.
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs2=5, use_rs2=1 → one cycle of load_pc=0, load_ifid=0, flush_idex=1. Next cycle all loads 1.
  - Same case with idex_rd=0 → no bubble.
- Redirect with load-use: br_taken=1 together with the load-use condition → flush_ifid=1, flush_idex=1, pc_redirect=1, load_pc=1.
- Redirect during freeze: br_taken=1 while a D-miss is pending 2 cycles → no flush while frozen. On the dmem_resp cycle: pc_redirect=1 and flushes asserted once, then redir_pend=0.
